// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-requester I2C command arbiter.
// Optional abort-on-timeout logic is enabled with I2C_ARB_TIMEOUT_EN.
package i2c_arb_pkg;

    localparam int NUM_REQ            = 2;
    localparam int PTR_W              = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NEWD_HOLD_DEF      = 48;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    function automatic logic [PTR_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (oh[i]) idx = PTR_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin picker: the requester after the
// last-granted one has highest priority.
module i2c_rr_picker
    import i2c_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ptr + PTR_W'(i);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Arbitrates two requesters onto one I2C master command port.
// Define I2C_ARB_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NEWD_HOLD      = NEWD_HOLD_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_wr,
    input  logic [NUM_REQ-1:0][6:0] req_addr,
    input  logic [NUM_REQ-1:0][7:0] req_wdata,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [7:0]              rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    m_newd,
    output logic                    m_wr,
    output logic [6:0]              m_addr,
    output logic [7:0]              m_wdata,
    input  logic [7:0]              m_rdata,
    input  logic                    m_done
);

    localparam int HOLD_W = $clog2(NEWD_HOLD + 1);

    if (NEWD_HOLD < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("i2c_req_arbiter: NEWD_HOLD must be >= 2, TIMEOUT_CYCLES >= 1");
    end

    arb_state_t         state, state_nxt;
    logic [PTR_W-1:0]   ptr, owner, win_idx;
    logic [NUM_REQ-1:0] win;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               done_q, done_seen, done_rise;
    logic               launch, to_hit;

    i2c_rr_picker u_picker (
        .req (req),
        .ptr (ptr),
        .win (win)
    );

    assign win_idx   = oh2idx(win);
    assign launch    = (state == ST_IDLE) && (|req);
    assign done_rise = m_done && !done_q;
    assign busy      = (state != ST_IDLE);
    assign m_newd    = (state == ST_LAUNCH);

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        rsp_valid = '0;
        unique case (state)
            ST_IDLE: begin
                // rst gate keeps gnt low while reset is held with req high
                if (launch) begin
                    gnt       = win & {NUM_REQ{rst}};
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (hold_cnt == HOLD_W'(NEWD_HOLD - 1))
                    state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_seen || to_hit)
                    state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[owner] = 1'b1;
                state_nxt        = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= PTR_W'(NUM_REQ - 1);
            owner     <= '0;
            m_wr      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            rsp_rdata <= '0;
            hold_cnt  <= '0;
            done_q    <= 1'b0;
            done_seen <= 1'b0;
        end else begin
            done_q <= m_done;
            if (launch) begin
                ptr       <= win_idx;
                owner     <= win_idx;
                m_wr      <= req_wr[win_idx];
                m_addr    <= req_addr[win_idx];
                m_wdata   <= req_wdata[win_idx];
                hold_cnt  <= '0;
                done_seen <= 1'b0;
            end else begin
                if (state == ST_LAUNCH)
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                if ((state == ST_LAUNCH || state == ST_WAIT) && done_rise)
                    done_seen <= 1'b1;
                if (state == ST_WAIT && done_seen && !m_wr)
                    rsp_rdata <= m_rdata;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            err_q;

    assign to_hit = (state == ST_WAIT) && !done_seen &&
                    (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (launch) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + TO_W'(1);
            if (to_hit) err_q <= 1'b1;
        end
    end

    assign rsp_err = (state == ST_RESP) && err_q;
`else
    assign to_hit  = 1'b0;
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed scoreboard bench for i2c_req_arbiter with a behavioural
// I2C master/EEPROM model behind the m_* port.
module tb_i2c_req_arbiter;

    localparam int HOLD = 48;
    localparam int TO   = 4096;

    typedef struct {
        int         id;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req;
    logic [1:0]      req_wr;
    logic [1:0][6:0] req_addr;
    logic [1:0][7:0] req_wdata;
    logic [1:0]      gnt;
    logic [1:0]      rsp_valid;
    logic [7:0]      rsp_rdata;
    logic            rsp_err;
    logic            busy;
    logic            m_newd;
    logic            m_wr;
    logic [6:0]      m_addr;
    logic [7:0]      m_wdata;
    logic [7:0]      m_rdata;
    logic            m_done;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rsp_cyc  = 0;
    int   gnt_cyc  = 0;
    int   n_rsp    = 0;
    int   idle_wait;
    bit   master_en = 1'b1;
    exp_t sb[$];
    logic [7:0] mem [128];

    i2c_req_arbiter #(
        .NEWD_HOLD      (HOLD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .m_newd    (m_newd),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_done    (m_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response scoreboard
    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] oh;
        if (rst === 1'b1 && rsp_valid !== 2'b00) begin
            n_rsp++;
            rsp_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e  = sb.pop_front();
                oh = 2'(1 << e.id);
                chk("rsp_id", 32'(rsp_valid), 32'(oh));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // Behavioural master: one command per m_newd burst, m_done held 3 cycles
    initial begin : master
        logic [6:0] a;
        logic [7:0] d;
        logic       w;
        int         len;
        m_done  = 1'b0;
        m_rdata = 8'h00;
        for (int i = 0; i < 128; i++) mem[i] = 8'h91;
        forever begin
            @(negedge clk);
            if (m_newd === 1'b1) begin
                a   = m_addr;
                d   = m_wdata;
                w   = m_wr;
                len = 0;
                while (m_newd === 1'b1 && len < 1000) begin
                    len++;
                    @(negedge clk);
                end
                chk("newd_len", 32'(len), 32'(HOLD));
                while (!master_en && busy && rst) @(negedge clk);
                if (busy && rst) begin
                    repeat (4) @(negedge clk);
                    chk("m_cmd_stable", {16'd0, w, a, d},
                        {16'd0, m_wr, m_addr, m_wdata});
                    if (w) mem[a] = d;
                    else   m_rdata = mem[a];
                    m_done = 1'b1;
                    repeat (3) @(negedge clk);
                    m_done = 1'b0;
                end
            end
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic wr,
                           input logic [6:0] addr, input logic [7:0] data);
        req_wr[id]    = wr;
        req_addr[id]  = addr;
        req_wdata[id] = data;
        req[id]       = 1'b1;
    endtask

    task automatic push(input int id, input logic [7:0] rd, input logic err);
        exp_t e;
        e.id    = id;
        e.rdata = rd;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic wait_gnt(input int id, input int budget);
        int         n;
        logic [1:0] oh;
        n         = 0;
        idle_wait = 0;
        oh        = 2'(1 << id);
        @(negedge clk);
        while (gnt === 2'b00 && n < budget) begin
            if (!busy) idle_wait++;
            @(negedge clk);
            n++;
        end
        chk("gnt_onehot", 32'(gnt), 32'(oh));
        gnt_cyc = cyc;
        @(posedge clk);
        #1;
        req[id] = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_newd_fall();
        int n;
        n = 0;
        while (m_newd !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("newd_fall", 32'(m_newd), 32'd0);
    endtask

    initial begin : stim
        int n0, cnt, t0;
        rst       = 1'b0;
        req       = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_newd", 32'(m_newd), 32'd0);
        chk("rst_m_wr", 32'(m_wr), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_m_wdata", 32'(m_wdata), 32'd0);
        go();
        rst = 1'b1;

        // first tie after reset: write 0x05=A7 by req0, read back by req1
        go();
        set_req(0, 1'b1, 7'h05, 8'hA7);
        set_req(1, 1'b0, 7'h05, 8'h00);
        push(0, 8'h00, 1'b0);
        push(1, 8'hA7, 1'b0);
        wait_gnt(0, 20);
        @(negedge clk);
        chk("cmd_latched", {16'd0, m_wr, m_addr, m_wdata},
            {16'd0, 1'b1, 7'h05, 8'hA7});
        chk("busy_launch", 32'(busy), 32'd1);
        wait_gnt(1, 500);
        chk("req1_busy_held", 32'(idle_wait), 32'd0);
        chk("gnt1_after_rsp0", 32'(gnt_cyc - rsp_cyc), 32'd1);
        wait_done(500);

        // second tie goes to req0 again
        go();
        set_req(0, 1'b0, 7'h22, 8'h00);
        set_req(1, 1'b1, 7'h22, 8'h5A);
        push(0, 8'h91, 1'b0);
        push(1, 8'h91, 1'b0);
        wait_gnt(0, 20);
        wait_gnt(1, 500);
        wait_done(500);

        // lone requester wins even if it was granted last
        go();
        set_req(1, 1'b0, 7'h22, 8'h00);
        push(1, 8'h5A, 1'b0);
        wait_gnt(1, 20);
        wait_done(500);

        // withdrawn request while busy leaves no trace
        go();
        set_req(0, 1'b0, 7'h05, 8'h00);
        push(0, 8'hA7, 1'b0);
        wait_gnt(0, 20);
        set_req(1, 1'b1, 7'h33, 8'hEE);
        repeat (10) go();
        req[1] = 1'b0;
        wait_done(500);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (gnt !== 2'b00) cnt++;
        end
        chk("withdraw_no_gnt", 32'(cnt), 32'd0);
        chk("withdraw_mem", 32'(mem[7'h33]), 32'h91);

`ifdef I2C_ARB_TIMEOUT_EN
        go();
        master_en = 1'b0;
        set_req(1, 1'b0, 7'h22, 8'h00);
        push(1, 8'hA7, 1'b1);
        wait_gnt(1, 20);
        wait_newd_fall();
        t0 = cyc;
        wait_done(TO + 500);
        chk("timeout_latency", 32'(rsp_cyc - t0), 32'(TO));
        master_en = 1'b1;
        go();
        set_req(1, 1'b0, 7'h22, 8'h00);
        push(1, 8'h5A, 1'b0);
        wait_gnt(1, 20);
        wait_done(500);
`else
        go();
        master_en = 1'b0;
        set_req(1, 1'b0, 7'h22, 8'h00);
        push(1, 8'h5A, 1'b0);
        wait_gnt(1, 20);
        n0 = n_rsp;
        repeat (300) @(negedge clk);
        chk("wait_forever_busy", 32'(busy), 32'd1);
        chk("wait_forever_no_rsp", 32'(n_rsp - n0), 32'd0);
        master_en = 1'b1;
        wait_done(500);
`endif

        // reset while in WAIT with req0 pending
        go();
        master_en = 1'b0;
        set_req(1, 1'b0, 7'h05, 8'h00);
        wait_gnt(1, 20);
        set_req(0, 1'b0, 7'h05, 8'h00);
        wait_newd_fall();
        repeat (5) @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("pend_no_gnt", 32'(gnt), 32'd0);
        n0 = n_rsp;
        go();
        rst = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_newd", 32'(m_newd), 32'd0);
        chk("mid_rst_cmd", {16'd0, m_wr, m_addr, m_wdata}, 32'd0);
        chk("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("mid_rst_err", 32'(rsp_err), 32'd0);
        repeat (3) go();
        rst       = 1'b1;
        master_en = 1'b1;
        push(0, 8'hA7, 1'b0);
        wait_gnt(0, 20);
        wait_done(500);
        chk("rst_dropped_rsp", 32'(n_rsp - n0), 32'd1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter NEWD_HOLD, default 48, number of clk cycles m_newd is held high per launch; must be at least 2 master bit-clock periods.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, clk cycles allowed in WAIT before abort; used only with I2C_ARB_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req  in  2  per-requester request; held high with fields stable until gnt.
REQ-006 req_wr  in  2  per-requester direction, 1=write, 0=read.
REQ-007 req_addr  in  2x7  per-requester 7-bit memory address.
REQ-008 req_wdata  in  2x8  per-requester write data.
REQ-009 gnt  out  2  one-cycle pulse; request captured.
REQ-010 rsp_valid  out  2  one-cycle pulse; transaction complete for that requester.
REQ-011 rsp_rdata  out  8  read data; valid with rsp_valid on reads.
REQ-012 rsp_err  out  1  timeout flag; valid with rsp_valid.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 m_newd, m_wr, m_addr[6:0], m_wdata[7:0]  out  drive the I2C master's command inputs.
REQ-015 m_rdata[7:0], m_done  in  master read data and completion flag; m_done may stay high for several clk cycles.

Function
REQ-016 FSM states: IDLE, LAUNCH, WAIT, RESP.
REQ-017 IDLE: if any req bit is high, select a winner, latch its wr/addr/wdata into m_wr/m_addr/m_wdata, pulse gnt[winner], and go to LAUNCH next cycle.
REQ-018 Arbitration: round-robin with a last-grant pointer; on simultaneous requests the requester not granted last wins; a lone requester always wins.
REQ-019 LAUNCH: m_newd=1 for exactly NEWD_HOLD cycles, then m_newd=0 and go to WAIT; the done-seen flag is cleared on LAUNCH entry.
REQ-020 The rising edge of m_done (registered compare) sets done-seen in LAUNCH or WAIT.
REQ-021 WAIT: when done-seen is set, capture m_rdata into rsp_rdata if it was a read, and go to RESP.
REQ-022 RESP: pulse rsp_valid[owner] for one cycle with rsp_err, then go to IDLE; the earliest next gnt is the following cycle.
REQ-023 m_wr/m_addr/m_wdata stay stable from gnt until RESP completes.
REQ-024 Requests arriving while busy are not granted; they remain pending and are arbitrated in IDLE.
REQ-025 A req that drops before gnt is withdrawn without side effects.
REQ-026 rsp_rdata holds its last value between responses; it is not updated on writes.

Reset
REQ-027 Asserting rst sets state=IDLE, gnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, m_newd=0, m_wr=0, m_addr=0, m_wdata=0, and last-grant pointer=1 (so requester 0 wins the first tie).
REQ-028 Reset mid-transaction drops the in-flight transaction with no rsp_valid.

Configuration
REQ-029 Macro I2C_ARB_TIMEOUT_EN defined: a WAIT counter aborts after TIMEOUT_CYCLES without done-seen and goes to RESP with rsp_err=1 and rsp_rdata unchanged.
REQ-030 Macro I2C_ARB_TIMEOUT_EN undefined: no counter, WAIT waits indefinitely, and rsp_err is tied 0.

Structure
REQ-031 Package i2c_arb_pkg holds the state enum, NUM_REQ=2, and default NEWD_HOLD/TIMEOUT_CYCLES constants.
REQ-032 Sub-module i2c_rr_picker is combinational: inputs req and the pointer; outputs a one-hot winner.

Verification
REQ-033 Req0 write addr 0x05 data 0xA7 -> gnt[0] pulse, m_newd high 48 cycles, then after m_done rise rsp_valid[0]=1 with rsp_err=0.
REQ-034 Req1 read addr 0x05 after the REQ-033 write -> rsp_valid[1] with rsp_rdata=0xA7; a read of a never-written address returns 0x91.
REQ-035 Req0 and req1 high in the same cycle after reset -> gnt[0] first; req1 granted the cycle after rsp_valid[0]; the next tie goes to 0.
REQ-036 Req1 asserted during a req0 transaction -> no gnt[1] until IDLE; busy stays high throughout.
REQ-037 Timeout build, m_done held 0 -> rsp_valid with rsp_err=1 after TIMEOUT_CYCLES; the next request proceeds normally.
REQ-038 rst low during WAIT -> all outputs at reset values, no rsp_valid, and the pending req is re-granted after release.
